wb_rr_arbiter: RTL

Round-robin Wishbone classic arbiter that shares one master port between NM requesting masters. It sits upstream of the address-decoding Wishbone router and drives that router's single master interface. The grant is held for the whole bus cycle while the winner's CYC is high. Non-granted masters are stalled: they get no ACK and no ERR.

---
 rtl/wb_rr_arbiter.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_rr_arbiter
//  Purpose  : Round-robin Wishbone classic arbiter. Shares one master port
//             between NM requesting masters and drives the single master
//             interface of the downstream address-decoding router. The
//             winner keeps the grant while its CYC stays high. Masters that
//             are not granted are stalled and see no ACK or ERR.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk, i_reset_n      clock, asynchronous active-low reset
//    i_mcyc/i_mstb/i_mwe   per-master CYC / STB / WE           [NM]
//    i_maddr               per-master address, master k at [k*AW +: AW]
//    i_mdata               per-master write data, master k at [k*DW +: DW]
//    i_msel                per-master byte selects, master k at [k*SW +: SW]
//    o_mack, o_merr        per-master ACK / ERR                [NM]
//    o_mdata               read data, broadcast to every master
//    o_scyc ... o_ssel     shared bus towards the router
//    i_sack, i_sdata,
//    i_serr                response from the router
//    o_grant               one-hot registered grant (status)
//
//  Optional feature (macro WB_RR_ARBITER_TIMEOUT_EN):
//    A watchdog counts STB cycles without ACK/ERR. On reaching TIMEOUT it
//    pulses o_merr of the owner for one cycle and holds o_scyc/o_sstb low
//    until the owner drops CYC. Without the macro the arbiter waits forever.
// ============================================================================
module wb_rr_arbiter #(
  parameter int NM      = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SW      = DW / 8,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [NM-1:0]    i_mcyc,
  input  logic [NM-1:0]    i_mstb,
  input  logic [NM-1:0]    i_mwe,
  input  logic [NM*AW-1:0] i_maddr,
  input  logic [NM*DW-1:0] i_mdata,
  input  logic [NM*SW-1:0] i_msel,
  output logic [NM-1:0]    o_mack,
  output logic [DW-1:0]    o_mdata,
  output logic [NM-1:0]    o_merr,
  output logic             o_scyc,
  output logic             o_sstb,
  output logic             o_swe,
  output logic [AW-1:0]    o_saddr,
  output logic [DW-1:0]    o_sdata,
  output logic [SW-1:0]    o_ssel,
  input  logic             i_sack,
  input  logic [DW-1:0]    i_sdata,
  input  logic             i_serr,
  output logic [NM-1:0]    o_grant
);

  localparam int PW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [NM-1:0] r_grant;
  logic [NM-1:0] w_grant_nxt;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic [PW-1:0] r_gidx;       // binary index of the current owner
  logic [PW-1:0] w_gidx_nxt;

  logic          w_busy;
  logic          w_any_req;
  logic [PW-1:0] w_win;
  logic [PW:0]   w_win_inc;

  // Watchdog hooks; tied off when the feature is compiled out.
  logic          w_tmo_hit;    // one-cycle timeout error pulse
  logic          w_tmo_block;  // bus forced idle after a timeout

  assign w_busy = (r_state == ST_BUSY);

  // --------------------------------------------------------------------------
  // Per-master slices as unpacked arrays so the owner mux is a plain index.
  // --------------------------------------------------------------------------
  logic [AW-1:0] w_addr_arr [NM];
  logic [DW-1:0] w_data_arr [NM];
  logic [SW-1:0] w_sel_arr  [NM];

  genvar gk;
  generate
    for (gk = 0; gk < NM; gk++) begin : g_slice
      assign w_addr_arr[gk] = i_maddr[gk*AW +: AW];
      assign w_data_arr[gk] = i_mdata[gk*DW +: DW];
      assign w_sel_arr[gk]  = i_msel[gk*SW +: SW];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Round-robin search: first CYC at or after the pointer, wrapping modulo NM.
  // Scanned from the farthest offset down so the nearest requester wins.
  // --------------------------------------------------------------------------
  always_comb begin
    logic [PW:0]   v_sum;
    logic [PW-1:0] v_idx;
    w_any_req = 1'b0;
    w_win     = '0;
    v_sum     = '0;
    v_idx     = '0;
    for (int i = NM - 1; i >= 0; i--) begin
      v_sum = {1'b0, r_ptr} + (PW+1)'(i);
      if (v_sum >= (PW+1)'(NM)) begin
        v_sum = v_sum - (PW+1)'(NM);
      end
      v_idx = v_sum[PW-1:0];
      if (i_mcyc[v_idx]) begin
        w_any_req = 1'b1;
        w_win     = v_idx;
      end
    end
  end

  assign w_win_inc = {1'b0, w_win} + 1'b1;

  // --------------------------------------------------------------------------
  // FSM next state. The pointer only moves on grant, never on release.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_gidx_nxt  = r_gidx;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = {{(NM-1){1'b0}}, 1'b1} << w_win;
          w_gidx_nxt  = w_win;
          w_ptr_nxt   = (w_win_inc == (PW+1)'(NM)) ? '0 : w_win_inc[PW-1:0];
        end
      end
      ST_BUSY: begin
        // Release leaves one dead cycle before the next owner is granted.
        if (!i_mcyc[r_gidx]) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_gidx  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gidx  <= w_gidx_nxt;
    end
  end

`ifdef WB_RR_ARBITER_TIMEOUT_EN
  // --------------------------------------------------------------------------
  // Watchdog: counts owner STB cycles since the last ACK/ERR or grant.
  // --------------------------------------------------------------------------
  localparam int TW = (TIMEOUT < 256) ? 8 : 16;
  localparam logic [TW-1:0] c_timeout = TW'(TIMEOUT);

  logic [TW-1:0] r_tcnt;
  logic          r_tdone;

  assign w_tmo_hit   = w_busy & ~r_tdone & (r_tcnt == c_timeout);
  assign w_tmo_block = r_tdone;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tcnt  <= '0;
      r_tdone <= 1'b0;
    end else if (!w_busy) begin
      // Held clear in IDLE, so every new grant starts from zero.
      r_tcnt  <= '0;
      r_tdone <= 1'b0;
    end else if (w_tmo_hit) begin
      r_tdone <= 1'b1;
    end else if (!r_tdone) begin
      if (i_sack || i_serr) begin
        r_tcnt <= '0;
      end else if (i_mstb[r_gidx]) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
    end
  end
`else
  assign w_tmo_hit   = 1'b0;
  assign w_tmo_block = 1'b0;

  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT != 0);
`endif

  // --------------------------------------------------------------------------
  // Shared bus and response routing. Everything is gated by BUSY so an
  // asynchronous reset silences the bus and drops any in-flight ACK at once.
  // --------------------------------------------------------------------------
  always_comb begin
    o_scyc  = 1'b0;
    o_sstb  = 1'b0;
    o_swe   = 1'b0;
    o_saddr = '0;
    o_sdata = '0;
    o_ssel  = '0;
    o_mack  = '0;
    o_merr  = '0;
    if (w_busy) begin
      o_scyc  = i_mcyc[r_gidx] & ~w_tmo_block;
      o_sstb  = i_mstb[r_gidx] & ~w_tmo_block;
      o_swe   = i_mwe[r_gidx];
      o_saddr = w_addr_arr[r_gidx];
      o_sdata = w_data_arr[r_gidx];
      o_ssel  = w_sel_arr[r_gidx];
      // Slave responses are ignored on and after a watchdog expiry.
      o_mack[r_gidx] = i_sack & ~w_tmo_block & ~w_tmo_hit;
      o_merr[r_gidx] = (i_serr & ~w_tmo_block & ~w_tmo_hit) | w_tmo_hit;
    end
  end

  assign o_mdata = i_sdata;
  assign o_grant = r_grant;

endmodule
`default_nettype wire
